la_readout: RTL and testbench
=============================

Name: la_readout

Overview:
- Control/readout stage directly downstream of logic_analyser, in the system clock domain.
- On a start command it arms the analyser, waits for the capture to complete, then walks the full capture memory.
- Each RLE word is streamed as bytes, MSB first, over a valid/ready byte interface toward the UART transmitter.
- Also reports busy status and pulses dump_done once the last byte is accepted.

Parameters:
- CAPTURE_DEPTH, 11, capture memory address width; WORDS = 2^CAPTURE_DEPTH.
- WORD_WIDTH, 32, capture word width. Must be a multiple of 8; BYTES = WORD_WIDTH/8.
- DONE_EDGES, 2, number of la_done rising edges after arm before the dump starts. The analyser raises done once on arming and once on completion.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  single-cycle request; ignored while busy.
- abort  in  1  cancels any operation; returns to IDLE.
- capture  out  1  single-cycle arm pulse to the analyser.
- la_done  in  1  level done flag from the analyser.
- mem_addr  out  CAPTURE_DEPTH  capture memory read address (registered).
- mem_data  in  WORD_WIDTH  read data, valid one cycle after mem_addr is sampled.
- tx_data  out  8  byte out.
- tx_valid  out  1  byte valid.
- tx_ready  in  1  sink ready; transfer occurs when tx_valid && tx_ready.
- busy  out  1  high from the cycle after start until return to IDLE.
- dump_done  out  1  single-cycle pulse when the final byte is accepted.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE.
  - capture, busy, tx_valid, dump_done = 0.
  - mem_addr = 0, tx_data = 0.
  - edge counter = 0, la_done_q = 0.
- States: IDLE, ARM, WAIT_DONE, FETCH, LOAD, SEND.
- IDLE:
  - start=1 → ARM. busy=1 from next cycle. The start cycle itself causes nothing else.
- ARM: exactly one cycle, capture=1, edge counter cleared → WAIT_DONE.
- WAIT_DONE:
  - rise = la_done && !la_done_q, where la_done_q is registered every cycle.
  - Each rise increments the counter.
  - On the rise that makes count == DONE_EDGES: mem_addr <= 0 → FETCH.
  - No timeout; only abort or rst exits.
- FETCH: one cycle, mem_addr stable → LOAD.
- LOAD:
  - Shift register <= mem_data.
  - tx_data <= mem_data[WORD_WIDTH-1 -: 8], tx_valid <= 1, byte index = 0 → SEND.
- SEND:
  - tx_data and tx_valid are held constant while tx_ready=0.
  - On a transfer with byte index < BYTES-1: shift left by 8, present the next byte the following cycle, index+1. tx_valid stays 1 with no bubble.
  - On a transfer of the last byte with mem_addr < WORDS-1: tx_valid <= 0, mem_addr <= mem_addr+1 → FETCH.
  - On a transfer of the last byte with mem_addr == WORDS-1: tx_valid <= 0, dump_done <= 1 for one cycle, busy <= 0 → IDLE. mem_addr does not wrap; it holds WORDS-1 until the next dump.
- Throughput: BYTES+2 cycles per word with tx_ready held at 1.
- abort:
  - Highest priority after rst in any non-IDLE state; next cycle state=IDLE.
  - tx_valid=0, busy=0, no dump_done.
  - Dropping tx_valid without a transfer is permitted only on abort.
  - abort in IDLE has no effect.
- Simultaneous events:
  - start with abort in IDLE: abort wins, stay IDLE.
  - start while busy: ignored, no effect on the dump in progress.
  - la_done rising edges outside WAIT_DONE are not counted.
- Byte order:
  - Big-endian per word, so the RLE data field goes out before the length byte.
  - Words go out in address order 0..WORDS-1.

Decomposition:
- Package la_pkg holds:
  - state encoding localparams;
  - BYTE_WIDTH=8;
  - the function computing BYTES from WORD_WIDTH.
- Sub-module word_serializer (WORD_WIDTH):
  - load/word input, byte valid/ready output, last-byte flag.
  - Owns the shift register and byte index.
- The top level keeps the sequencing FSM, edge counter and address counter.

Test Plan:
- CAPTURE_DEPTH=2, memory model word[a]=32'hA0B0C0D0+a, tx_ready=1, start, then two la_done rises → 16 bytes A0 B0 C0 D0 A0 B0 C0 D1 … D3. dump_done pulses once on the cycle after byte 16. capture pulsed exactly once, one cycle after start.
- Same setup with a single la_done rise only → no tx_valid for 100 cycles. busy=1, state stays WAIT_DONE.
- Random tx_ready (about 30% duty) → identical 16-byte sequence. tx_data is stable across every stalled cycle. No byte is dropped or duplicated.
- start pulsed again during SEND → output sequence unchanged, no second capture pulse.
- abort asserted after byte 6 → tx_valid=0 and busy=0 next cycle, no dump_done. A new start then yields the full 16 bytes from address 0.
- rst asserted mid-SEND for one cycle → all outputs at reset values next cycle. The subsequent start/dump is correct.

Source files
------------

// File: rtl/la_pkg.sv
// Shared types and constants for the logic-analyser readout stage.
// State encoding, byte width and word-to-byte helper.
package la_pkg;

  localparam int BYTE_WIDTH = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARM   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_FETCH = 3'd3;
  localparam logic [2:0] ST_LOAD  = 3'd4;
  localparam logic [2:0] ST_SEND  = 3'd5;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    ARM       = ST_ARM,
    WAIT_DONE = ST_WAIT,
    FETCH     = ST_FETCH,
    LOAD      = ST_LOAD,
    SEND      = ST_SEND
  } state_t;

  function automatic int bytes_of(input int width);
    return width / BYTE_WIDTH;
  endfunction

endpackage

// File: rtl/la_readout_if.sv
// Byte stream toward the UART transmitter.
// Transfer happens on a cycle where valid and ready are both high.
interface la_readout_if;
  import la_pkg::*;

  logic [BYTE_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, valid, input ready);
  modport slave  (input data, valid, output ready);

endinterface

// File: rtl/la_readout_serializer.sv
// Splits one capture word into bytes, MSB first.
// Holds the byte steady until the sink accepts it.
module word_serializer
  import la_pkg::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  clear,
  input  logic [WORD_WIDTH-1:0] word,
  output logic                  fire,
  output logic                  last,
  la_readout_if.master          tx
);

  localparam int BYTES = bytes_of(WORD_WIDTH);
  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [WORD_WIDTH-1:0] sr;
  logic [WORD_WIDTH-1:0] nxt;
  logic [IW-1:0]         idx;

  assign nxt  = sr << BYTE_WIDTH;
  assign fire = tx.valid & tx.ready;
  assign last = (idx == IW'(BYTES - 1));

  // Shift register, byte index and the registered byte output.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr       <= '0;
      idx      <= '0;
      tx.data  <= '0;
      tx.valid <= 1'b0;
    end else if (clear) begin
      tx.valid <= 1'b0;
    end else if (load) begin
      sr       <= word;
      idx      <= '0;
      tx.data  <= word[WORD_WIDTH-1 -: BYTE_WIDTH];
      tx.valid <= 1'b1;
    end else if (fire) begin
      if (!last) begin
        sr      <= nxt;
        idx     <= idx + 1'b1;
        tx.data <= nxt[WORD_WIDTH-1 -: BYTE_WIDTH];
      end else begin
        tx.valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/la_readout.sv
// Arms the analyser, waits for capture completion,
// then streams the whole capture memory out bytewise.
module la_readout
  import la_pkg::*;
#(
  parameter int CAPTURE_DEPTH = 11,
  parameter int WORD_WIDTH    = 32,
  parameter int DONE_EDGES    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  output logic                     capture,
  input  logic                     la_done,
  output logic [CAPTURE_DEPTH-1:0] mem_addr,
  input  logic [WORD_WIDTH-1:0]    mem_data,
  la_readout_if.master             tx,
  output logic                     busy,
  output logic                     dump_done
);

  localparam int CW = $clog2(DONE_EDGES + 1);

  state_t                   state, state_n;
  logic [CW-1:0]            cnt, cnt_n;
  logic [CAPTURE_DEPTH-1:0] addr_n;
  logic                     la_done_q;
  logic                     rise;
  logic                     done_n;
  logic                     load, clear;
  logic                     fire, last;
  logic                     last_addr;

  assign rise      = la_done & ~la_done_q;
  assign last_addr = &mem_addr;
  assign busy      = (state != IDLE);

  // Next-state, counters and control strobes; abort overrides all.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = mem_addr;
    done_n  = 1'b0;
    load    = 1'b0;
    clear   = 1'b0;
    capture = 1'b0;
    if (abort && state != IDLE) begin
      state_n = IDLE;
      clear   = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !abort) state_n = ARM;
        end
        ARM: begin
          capture = 1'b1;
          cnt_n   = '0;
          state_n = WAIT_DONE;
        end
        WAIT_DONE: begin
          if (rise) begin
            cnt_n = cnt + 1'b1;
            if (cnt_n == CW'(DONE_EDGES)) begin
              addr_n  = '0;
              state_n = FETCH;
            end
          end
        end
        FETCH: state_n = LOAD;
        LOAD: begin
          load    = 1'b1;
          state_n = SEND;
        end
        SEND: begin
          if (fire && last) begin
            if (last_addr) begin
              done_n  = 1'b1;
              state_n = IDLE;
            end else begin
              addr_n  = mem_addr + 1'b1;
              state_n = FETCH;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State, counters and registered pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_addr  <= '0;
      la_done_q <= 1'b0;
      dump_done <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mem_addr  <= addr_n;
      la_done_q <= la_done;
      dump_done <= done_n;
    end
  end

  word_serializer #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_ser (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .clear(clear),
    .word (mem_data),
    .fire (fire),
    .last (last),
    .tx   (tx)
  );

endmodule

// File: tb/tb_la_readout.sv
// Self-checking bench for la_readout with a small capture memory.
// Expected bytes come from a word-level model of the memory contents.
module tb_la_readout;
  import la_pkg::*;

  localparam int CD    = 2;
  localparam int WW    = 32;
  localparam int WORDS = 4;
  localparam int BYTES = 4;
  localparam int NB    = WORDS * BYTES;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          la_done = 1'b0;
  logic          capture, busy, dump_done;
  logic [CD-1:0] mem_addr;
  logic [WW-1:0] mem_data;

  la_readout_if tx();

  la_readout #(
    .CAPTURE_DEPTH(CD),
    .WORD_WIDTH   (WW),
    .DONE_EDGES   (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .capture  (capture),
    .la_done  (la_done),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .tx       (tx),
    .busy     (busy),
    .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    mem_data <= 32'hA0B0C0D0 + 32'(mem_addr);

  int passed = 0;
  int total  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs[$];
  int cyc = 0;
  int cap_cnt, done_cnt, valid_cnt, stall_err;
  int first_x, last_x, start_cyc, cap_cyc, done_cyc;
  bit prev_hold = 0;
  logic [7:0] prev_data;
  bit rnd_ready = 0;

  // Observer: sampled mid-cycle, sees what the next edge will act on.
  always @(negedge clk) begin
    cyc++;
    if (prev_hold && (tx.valid !== 1'b1 || tx.data !== prev_data))
      stall_err++;
    prev_hold = tx.valid && !tx.ready && !abort && !rst;
    prev_data = tx.data;
    if (tx.valid && tx.ready) begin
      if (obs.size() == 0) first_x = cyc;
      last_x = cyc;
      obs.push_back(tx.data);
    end
    if (tx.valid) valid_cnt++;
    if (capture) begin cap_cnt++; cap_cyc = cyc; end
    if (dump_done) begin done_cnt++; done_cyc = cyc; end
    if (start) start_cyc = cyc;
  end

  // Sink with roughly 30% ready duty when enabled.
  always @(posedge clk) begin
    #1;
    if (rnd_ready) tx.ready = ($urandom_range(0, 9) < 3);
  end

  function automatic void build_exp();
    logic [31:0] w;
    exp_q.delete();
    for (int a = 0; a < WORDS; a++) begin
      w = 32'hA0B0C0D0 + 32'(a);
      for (int b = 0; b < BYTES; b++)
        exp_q.push_back(8'((w / (32'd1 << (8 * (BYTES - 1 - b)))) % 256));
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    obs.delete();
    cap_cnt = 0; done_cnt = 0; valid_cnt = 0; stall_err = 0;
    first_x = -1; last_x = -1; start_cyc = -1;
    cap_cyc = -1; done_cyc = -1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic done_pulse();
    la_done = 1'b1;
    repeat (3) tick();
    la_done = 1'b0;
    repeat (3) tick();
  endtask

  task automatic arm(input int edges, output bit ok);
    pulse_start();
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (capture) begin ok = 1; break; end
      tick();
    end
    if (ok) tick();
    repeat (edges) done_pulse();
  endtask

  task automatic wait_dump(output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (dump_done) begin ok = 1; break; end
      tick();
    end
    tick();
  endtask

  task automatic wait_bytes(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      if (obs.size() >= n) begin ok = 1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx.ready = 1'b1;
    repeat (3) tick();
    total++;
    if ({capture, busy, tx.valid, dump_done} !== 4'b0)
      $display("FAIL reset_ctl got=%b want=0000",
               {capture, busy, tx.valid, dump_done});
    else passed++;
    total++;
    if (mem_addr !== '0) $display("FAIL reset_addr got=%0d want=0", mem_addr);
    else passed++;
    total++;
    if (tx.data !== 8'h00) $display("FAIL reset_data got=%h want=00", tx.data);
    else passed++;
    rst = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0) $display("FAIL idle_busy got=%b want=0", busy);
    else passed++;
  endtask

  task automatic test_basic_dump();
    bit ok;
    tx.ready = 1'b1;
    clear_mon();
    arm(2, ok);
    total++;
    if (!ok) $display("FAIL basic_arm got=%0d want=1", ok);
    else passed++;
    wait_dump(ok);
    total++;
    if (!ok) $display("FAIL basic_done_timeout got=%0d want=1", ok);
    else passed++;
    total++;
    if (obs.size() != NB) $display("FAIL basic_len got=%0d want=%0d", obs.size(), NB);
    else passed++;
    for (int i = 0; i < NB; i++) begin
      total++;
      if (i >= obs.size() || obs[i] !== exp_q[i])
        $display("FAIL basic_byte%0d got=%h want=%h", i,
                 (i < obs.size()) ? obs[i] : 8'hxx, exp_q[i]);
      else passed++;
    end
    total++;
    if (cap_cnt != 1) $display("FAIL basic_cap_cnt got=%0d want=1", cap_cnt);
    else passed++;
    total++;
    if (cap_cyc != start_cyc + 1)
      $display("FAIL basic_cap_time got=%0d want=%0d", cap_cyc, start_cyc + 1);
    else passed++;
    total++;
    if (done_cnt != 1) $display("FAIL basic_done_cnt got=%0d want=1", done_cnt);
    else passed++;
    total++;
    if (done_cyc != last_x + 1)
      $display("FAIL basic_done_time got=%0d want=%0d", done_cyc, last_x + 1);
    else passed++;
    total++;
    if (last_x - first_x != (WORDS - 1) * (BYTES + 2) + BYTES - 1)
      $display("FAIL basic_rate got=%0d want=%0d", last_x - first_x,
               (WORDS - 1) * (BYTES + 2) + BYTES - 1);
    else passed++;
    total++;
    if (busy !== 1'b0 || mem_addr !== CD'(WORDS - 1))
      $display("FAIL basic_end got=%b/%0d want=0/%0d", busy, mem_addr, WORDS - 1);
    else passed++;
  endtask

  task automatic test_single_edge();
    bit ok;
    tx.ready = 1'b1;
    clear_mon();
    done_pulse();
    done_pulse();
    arm(1, ok);
    total++;
    if (!ok) $display("FAIL single_arm got=%0d want=1", ok);
    else passed++;
    repeat (100) tick();
    total++;
    if (valid_cnt != 0) $display("FAIL single_valid got=%0d want=0", valid_cnt);
    else passed++;
    total++;
    if (busy !== 1'b1) $display("FAIL single_busy got=%b want=1", busy);
    else passed++;
    total++;
    if (dut.state !== WAIT_DONE)
      $display("FAIL single_state got=%0d want=%0d", dut.state, WAIT_DONE);
    else passed++;
    done_pulse();
    wait_dump(ok);
    total++;
    if (!ok || obs.size() != NB)
      $display("FAIL single_resume got=%0d want=%0d", obs.size(), NB);
    else passed++;
  endtask

  task automatic test_random_ready();
    bit ok;
    clear_mon();
    rnd_ready = 1;
    arm(2, ok);
    wait_dump(ok);
    rnd_ready = 0;
    tx.ready = 1'b1;
    total++;
    if (!ok) $display("FAIL rand_timeout got=%0d want=1", ok);
    else passed++;
    total++;
    if (obs.size() != NB) $display("FAIL rand_len got=%0d want=%0d", obs.size(), NB);
    else passed++;
    for (int i = 0; i < NB; i++) begin
      total++;
      if (i >= obs.size() || obs[i] !== exp_q[i])
        $display("FAIL rand_byte%0d got=%h want=%h", i,
                 (i < obs.size()) ? obs[i] : 8'hxx, exp_q[i]);
      else passed++;
    end
    total++;
    if (stall_err != 0) $display("FAIL rand_stall got=%0d want=0", stall_err);
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    tx.ready = 1'b1;
    clear_mon();
    arm(2, ok);
    wait_bytes(5, ok);
    pulse_start();
    wait_dump(ok);
    total++;
    if (obs.size() != NB) $display("FAIL restart_len got=%0d want=%0d", obs.size(), NB);
    else passed++;
    for (int i = 0; i < NB; i++) begin
      total++;
      if (i >= obs.size() || obs[i] !== exp_q[i])
        $display("FAIL restart_byte%0d got=%h want=%h", i,
                 (i < obs.size()) ? obs[i] : 8'hxx, exp_q[i]);
      else passed++;
    end
    total++;
    if (cap_cnt != 1) $display("FAIL restart_cap got=%0d want=1", cap_cnt);
    else passed++;
  endtask

  task automatic test_abort();
    bit ok;
    tx.ready = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || capture !== 1'b0)
      $display("FAIL abort_idle got=%b%b want=00", busy, capture);
    else passed++;
    clear_mon();
    arm(2, ok);
    wait_bytes(6, ok);
    total++;
    if (!ok) $display("FAIL abort_reach got=%0d want=1", obs.size());
    else passed++;
    abort = 1'b1;
    tx.ready = 1'b0;
    tick();
    abort = 1'b0;
    total++;
    if (tx.valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL abort_out got=%b%b want=00", tx.valid, busy);
    else passed++;
    tx.ready = 1'b1;
    repeat (5) tick();
    total++;
    if (done_cnt != 0) $display("FAIL abort_nodone got=%0d want=0", done_cnt);
    else passed++;
    clear_mon();
    arm(2, ok);
    wait_dump(ok);
    total++;
    if (obs.size() != NB) $display("FAIL abort_redo_len got=%0d want=%0d", obs.size(), NB);
    else passed++;
    for (int i = 0; i < NB; i++) begin
      total++;
      if (i >= obs.size() || obs[i] !== exp_q[i])
        $display("FAIL abort_redo%0d got=%h want=%h", i,
                 (i < obs.size()) ? obs[i] : 8'hxx, exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_send();
    bit ok;
    tx.ready = 1'b1;
    clear_mon();
    arm(2, ok);
    wait_bytes(9, ok);
    rst = 1'b1;
    tick();
    total++;
    if ({capture, busy, tx.valid, dump_done} !== 4'b0)
      $display("FAIL rstmid_ctl got=%b want=0000",
               {capture, busy, tx.valid, dump_done});
    else passed++;
    total++;
    if (mem_addr !== '0 || tx.data !== 8'h00)
      $display("FAIL rstmid_regs got=%0d/%h want=0/00", mem_addr, tx.data);
    else passed++;
    rst = 1'b0;
    tick();
    clear_mon();
    arm(2, ok);
    wait_dump(ok);
    total++;
    if (obs.size() != NB) $display("FAIL rstmid_len got=%0d want=%0d", obs.size(), NB);
    else passed++;
    for (int i = 0; i < NB; i++) begin
      total++;
      if (i >= obs.size() || obs[i] !== exp_q[i])
        $display("FAIL rstmid_byte%0d got=%h want=%h", i,
                 (i < obs.size()) ? obs[i] : 8'hxx, exp_q[i]);
      else passed++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    build_exp();
    test_reset();
    test_basic_dump();
    test_single_edge();
    test_random_ready();
    test_back_to_back();
    test_abort();
    test_reset_mid_send();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
